// File: rtl/encoder4x2_debounce_if.sv
// Request/encoded-code bundle for encoder4x2_debounce.
// The master drives the raw lines, and the slave (the encoder) returns the code and flags.
interface encoder4x2_debounce_if;
    logic [3:0] in_n;
    logic [1:0] code;
    logic       valid;
    logic       strobe;
    logic       multi;

    modport master (output in_n, input code, valid, strobe, multi);
    modport slave  (input in_n, output code, valid, strobe, multi);
endinterface

// File: rtl/encoder4x2_debounce.sv
// Synchronizes and debounces four active-low request lines.
// It then priority-encodes the committed pattern into {a,b} and adds valid, strobe and multi flags.
module encoder4x2_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    encoder4x2_debounce_if.slave  bus
);
    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]      ALL_IDLE = 4'b1111;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUALIFY = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;

    logic [3:0]    sync1;
    logic [3:0]    s;
    logic [3:0]    candidate;
    logic [3:0]    committed;
    logic [CW-1:0] counter;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          commit;
    logic [1:0]    enc_code;
    logic [2:0]    low_count;
    logic          enc_multi;

    // A pattern change on the would-be commit edge fails s==candidate, so it restarts the count.
    always_comb begin
        commit = (s == candidate) && (counter == CNT_MAX) && (candidate != committed);
    end

    always_comb begin
        enc_code = '0;
        if (!candidate[3])      enc_code = 2'd3;
        else if (!candidate[2]) enc_code = 2'd2;
        else if (!candidate[1]) enc_code = 2'd1;
        low_count = {2'b00, ~candidate[0]} + {2'b00, ~candidate[1]}
                  + {2'b00, ~candidate[2]} + {2'b00, ~candidate[3]};
        enc_multi = (low_count > 3'd1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACTIVE: begin
                if (s != candidate) state_next = QUALIFY;
            end
            QUALIFY: begin
                if (commit)
                    state_next = (candidate == ALL_IDLE) ? IDLE : ACTIVE;
                else if (s == committed)
                    state_next = (committed == ALL_IDLE) ? IDLE : ACTIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= ALL_IDLE;
            s          <= ALL_IDLE;
            candidate  <= ALL_IDLE;
            committed  <= ALL_IDLE;
            counter    <= '0;
            state      <= IDLE;
            bus.code   <= '0;
            bus.valid  <= 1'b0;
            bus.strobe <= 1'b0;
            bus.multi  <= 1'b0;
        end else begin
            sync1 <= bus.in_n;
            s     <= sync1;
            state <= state_next;

            if (s != candidate) begin
                candidate <= s;
                counter   <= '0;
            end else if (counter < CNT_MAX) begin
                counter <= counter + 1'b1;
            end

            bus.strobe <= 1'b0;
            if (commit) begin
                committed  <= candidate;
                bus.valid  <= (candidate != ALL_IDLE);
                bus.code   <= enc_code;
                bus.multi  <= enc_multi;
                bus.strobe <= (candidate != ALL_IDLE);
            end
        end
    end
endmodule

// File: tb/tb_encoder4x2_debounce.sv
// Scoreboard bench for encoder4x2_debounce: directed press/release/glitch/reset vectors,
// with a negedge monitor that checks every output event against queued expectations.
module tb_encoder4x2_debounce;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    encoder4x2_debounce_if bus ();
    encoder4x2_debounce_if bus1 ();

    encoder4x2_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    encoder4x2_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    assign bus1.in_n = bus.in_n;

    typedef struct {
        logic [1:0]  code;
        logic        valid;
        logic        multi;
        logic        strobe;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  pat;
        int unsigned hold;
        logic        commits;
        logic [1:0]  code;
        logic        valid;
        logic        multi;
    } vec_t;

    exp_t        sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    logic [3:0]  prev = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Any strobe or change of {code,valid,multi} is an output event and must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.strobe !== 1'b0 || {bus.code, bus.valid, bus.multi} !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got code=%b valid=%b multi=%b strobe=%b at cyc %0d, required no output change",
                             bus.code, bus.valid, bus.multi, bus.strobe, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.code !== e.code || bus.valid !== e.valid || bus.multi !== e.multi ||
                        bus.strobe !== e.strobe || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL commit_event: got code=%b valid=%b multi=%b strobe=%b cyc=%0d, required code=%b valid=%b multi=%b strobe=%b cyc=%0d",
                                 bus.code, bus.valid, bus.multi, bus.strobe, cyc,
                                 e.code, e.valid, e.multi, e.strobe, e.cyc);
                    end
                end
            end
        end
        prev = {bus.code, bus.valid, bus.multi};
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    // Drive at a negedge; a committing pattern lands D+3 counted edges later.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.in_n = v.pat;
        if (v.commits) begin
            e.code   = v.code;
            e.valid  = v.valid;
            e.multi  = v.multi;
            e.strobe = v.valid;
            e.cyc    = cyc + D + 3;
            sb.push_back(e);
        end
        repeat (v.hold - 1) @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int unsigned c;

        vecs = '{
            '{4'b1110, 10, 1'b1, 2'b00, 1'b1, 1'b0},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0},
            '{4'b1101, 10, 1'b1, 2'b01, 1'b1, 1'b0},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0},
            '{4'b1011, 10, 1'b1, 2'b10, 1'b1, 1'b0},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0},
            '{4'b0111, 10, 1'b1, 2'b11, 1'b1, 1'b0},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0},
            '{4'b1010, 10, 1'b1, 2'b10, 1'b1, 1'b1},
            '{4'b0010, 10, 1'b1, 2'b11, 1'b1, 1'b1},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0},
            '{4'b1110, 10, 1'b1, 2'b00, 1'b1, 1'b0},
            '{4'b1011,  3, 1'b0, 2'b00, 1'b0, 1'b0},
            '{4'b1110, 10, 1'b0, 2'b00, 1'b0, 1'b0},
            '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0}
        };

        rst_n    = 1'b0;
        bus.in_n = 4'b1111;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.code, bus.valid, bus.strobe, bus.multi}, 5'b00000);
        check("reset_outputs_d1", {bus1.code, bus1.valid, bus1.strobe, bus1.multi}, 5'b00000);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_hold", {bus.code, bus.valid, bus.strobe, bus.multi}, 5'b00000);

        // Single press, with the DEBOUNCE_CYCLES=1 instance checked for its 3-edge latency.
        @(negedge clk);
        c = cyc;
        bus.in_n = 4'b1011;
        sb.push_back('{2'b10, 1'b1, 1'b0, 1'b1, c + D + 3});
        repeat (3) @(negedge clk);
        check("d1_before_commit", {bus1.code, bus1.valid, bus1.strobe, bus1.multi}, 5'b00000);
        @(negedge clk);
        check("d1_commit", {bus1.code, bus1.valid, bus1.strobe, bus1.multi}, 5'b10110);
        @(negedge clk);
        check("d1_strobe_drop", {bus1.code, bus1.valid, bus1.strobe, bus1.multi}, 5'b10100);
        repeat (7) @(negedge clk);
        v = '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0};
        apply(v);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset at edge 4 of a qualify discards the progress, and a full latency follows release.
        @(negedge clk);
        bus.in_n = 4'b0111;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midqual_reset", {bus.code, bus.valid, bus.strobe, bus.multi}, 5'b00000);
        @(negedge clk);
        check("midqual_reset_d1", {bus1.code, bus1.valid, bus1.strobe, bus1.multi}, 5'b00000);
        rst_n = 1'b1;
        sb.push_back('{2'b11, 1'b1, 1'b0, 1'b1, cyc + D + 3});
        repeat (12) @(negedge clk);
        v = '{4'b1111, 10, 1'b1, 2'b00, 1'b0, 1'b0};
        apply(v);
        repeat (5) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d expected events never seen, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/encoder4x2_debounce.md
Name: encoder4x2_debounce

Overview:
Inverse of the team's 2x4 active-low decoder. It takes a 4-line active-low one-hot bus (pushbuttons, or a decoder output looped back), synchronizes and debounces it, then priority-encodes it into the 2-bit {a,b} code. It sits between raw board inputs and control logic, giving a clean code, a level valid flag and a one-cycle strobe per accepted press.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive identical synchronized samples needed before a pattern is committed; legal range is 1 or greater.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_n  input  4  active-low request lines, asynchronous to clk; bit i low means line i is active.
code  output  2  registered encoded index, code[1]=a, code[0]=b.
valid  output  1  registered level; high while the committed pattern has at least one active line.
strobe  output  1  registered one-cycle pulse on each commit of a new non-idle pattern.
multi  output  1  registered flag; high when the committed pattern has more than one active line.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset, asynchronous on rst_n low:
  - Outputs: code=2'b00, valid=0, strobe=0, multi=0.
  - Internal: both sync stages=4'b1111, candidate=4'b1111, committed=4'b1111, counter=0, state=IDLE.
  - Reset mid-debounce or mid-ACTIVE discards all progress. After release, the bench sees full latency again.
- Synchronizer:
  - Two flops on in_n; s is the second stage.
  - No logic runs on unsynchronized in_n.
- Debounce, evaluated every edge:
  - If s != candidate: load candidate<=s and counter<=0.
  - Else if counter < DEBOUNCE_CYCLES-1: counter increments.
  - Else the counter saturates.
  - Commit condition: s==candidate AND counter==DEBOUNCE_CYCLES-1 AND candidate != committed. Commit takes effect at that edge.
  - Counter width is clog2(DEBOUNCE_CYCLES)+1 bits. It never wraps.
- State machine:
  - IDLE: committed pattern is 4'b1111. A change of s moves to QUALIFY.
  - QUALIFY: a candidate is being counted.
    - Commit of a non-idle pattern goes to ACTIVE.
    - Commit of 4'b1111 goes to IDLE.
    - If candidate returns equal to committed before the count completes, return to the prior state (IDLE or ACTIVE) with no output change.
  - ACTIVE: committed pattern is non-idle. A change of s moves to QUALIFY.
- Outputs on commit:
  - committed<=candidate.
  - valid<=(candidate != 4'b1111).
  - code<=index of the highest-numbered low bit (priority: bit3 > bit2 > bit1 > bit0); code=2'b00 when idle.
  - multi<=(two or more low bits).
  - strobe<=1 only if the new pattern is non-idle.
- Strobe rules:
  - strobe is 0 on every cycle without a commit.
  - A commit from one non-idle pattern to a different non-idle pattern (e.g. 1110 to 0110) pulses strobe again.
- Latency: with in_n stable from before rising edge 0, outputs update after edge DEBOUNCE_CYCLES+2. That is edge 6 for the default, edge 3 when DEBOUNCE_CYCLES=1.
- Glitches: a change lasting fewer than DEBOUNCE_CYCLES synchronized samples never commits. Outputs hold their prior committed values throughout.
- Release: returning to 4'b1111 is debounced identically. valid and multi clear and code goes to 00 at commit; no strobe.
- Simultaneous events: reset dominates all. A pattern change on the same edge that would have committed restarts the count; no commit occurs.

Test Plan:
- Reset then idle: rst_n=0, in_n=1111 -> code=00, valid=0, strobe=0, multi=0. These hold indefinitely after rst_n=1.
- Single press, DEBOUNCE_CYCLES=4: in_n=1011 stable from edge 0 -> after edge 6, code=10, valid=1, multi=0. strobe is high for exactly one cycle, the cycle after edge 6.
- Sweep: each of 1110/1101/1011/0111 held 10 cycles with idle between -> codes 00/01/10/11 respectively. Exactly one strobe each; valid drops after each release with no strobe.
- Multi-press and priority: in_n=1010 -> code=10, multi=1. Then in_n=0010 -> a new commit gives code=11, multi=1, and a second strobe.
- Glitch rejection: committed 1110, then in_n=1011 for 3 cycles then back to 1110 -> no output change, no strobe.
- Async reset mid-qualify: in_n=0111, assert rst_n=0 at edge 4 for 2 cycles then release -> outputs stay at reset values. Commit occurs at DEBOUNCE_CYCLES+2 edges after the first post-reset edge; code=11, strobe=1.
